// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared constants for the immediate generator:
//   XLEN        - width of the generated immediate (32)
//   IMM_W       - width of the raw immediate field fed in (21)
//   *_FORMAT    - 3-bit immediate-format selector codes
// Optional feature macro used by this slice: IMM_GEN_J_FORMAT_EN
// -----------------------------------------------------------------------------
package imm_gen_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 21;

  localparam logic [2:0] I_S_FORMAT = 3'b001;
  localparam logic [2:0] J_FORMAT   = 3'b010;
  localparam logic [2:0] B_FORMAT   = 3'b011;
  localparam logic [2:0] U_FORMAT   = 3'b100;

endpackage : imm_gen_pkg

// File: rtl/imm_sign_ext.sv
// -----------------------------------------------------------------------------
// imm_sign_ext
// Purely combinational sign-extender: replicates the MSB of din_i up to
// OUT_W bits.
// Ports:
//   din_i  [IN_W-1:0]   value to extend, din_i[IN_W-1] is the sign
//   dout_o [OUT_W-1:0]  sign-extended result
// -----------------------------------------------------------------------------
module imm_sign_ext #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o
);

  assign dout_o = {{(OUT_W - IN_W){din_i[IN_W-1]}}, din_i};

endmodule : imm_sign_ext

// File: rtl/imm_gen_block.sv
// -----------------------------------------------------------------------------
// imm_gen_block
// Registered immediate generator. Each cycle the raw immediate field is
// decoded according to the format selector and the 32-bit result is
// registered, giving exactly one cycle of latency and one result per cycle.
// There is no valid/ready handshake: inputs are sampled on every rising edge
// and imm_out simply tracks them with a one-cycle lag.
//
// Ports:
//   clk      single clock, all state updates on the rising edge
//   rst      synchronous, active-high reset; clears imm_out
//   opcode   [2:0]       immediate-format selector (see imm_gen_pkg)
//   imm      [IMM_W-1:0] raw immediate field bits, already extracted
//   imm_out  [XLEN-1:0]  generated immediate, registered
//
// Optional feature macro: IMM_GEN_J_FORMAT_EN
//   defined   -> opcode J_FORMAT decodes a 21-bit jump offset
//   undefined -> opcode J_FORMAT falls to the default and yields zero
// -----------------------------------------------------------------------------
module imm_gen_block
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = imm_gen_pkg::XLEN,
  parameter int IMM_W = imm_gen_pkg::IMM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [IMM_W-1:0] imm,
  output logic [XLEN-1:0]  imm_out
);

  // ---------------------------------------------------------------------------
  // Per-format candidate values
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;

  // I/S: 12-bit signed immediate, bit 11 is the sign.
  imm_sign_ext #(
    .IN_W  (12),
    .OUT_W (XLEN)
  ) u_sext_i_s (
    .din_i  (imm[11:0]),
    .dout_o (imm_i_s)
  );

  // B: imm[11:0] are offset bits [12:1]; bit 0 of a branch offset is always 0.
  imm_sign_ext #(
    .IN_W  (13),
    .OUT_W (XLEN)
  ) u_sext_b (
    .din_i  ({imm[11:0], 1'b0}),
    .dout_o (imm_b)
  );

  // U: upper 20 bits, low 12 zero; no extension needed.
  assign imm_u = {imm[19:0], 12'b0};

`ifdef IMM_GEN_J_FORMAT_EN
  logic [XLEN-1:0] imm_j;

  // J: imm[19:0] are offset bits [20:1]; imm[19] is the sign.
  imm_sign_ext #(
    .IN_W  (21),
    .OUT_W (XLEN)
  ) u_sext_j (
    .din_i  ({imm[19:0], 1'b0}),
    .dout_o (imm_j)
  );
`endif

  // imm[20] is not consumed by any supported format.
  logic unused_imm_msb;
  assign unused_imm_msb = imm[20];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_out_d;
  logic [XLEN-1:0] imm_out_q;

  always_comb begin
    imm_out_d = '0;
    case (opcode)
      I_S_FORMAT: imm_out_d = imm_i_s;
      B_FORMAT:   imm_out_d = imm_b;
      U_FORMAT:   imm_out_d = imm_u;
`ifdef IMM_GEN_J_FORMAT_EN
      J_FORMAT:   imm_out_d = imm_j;
`endif
      default:    imm_out_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register; reset wins over any input and drops the in-flight result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_out_q <= '0;
    end else begin
      imm_out_q <= imm_out_d;
    end
  end

  assign imm_out = imm_out_q;

endmodule : imm_gen_block

// File: tb/tb_imm_gen_block.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_block
// Self-checking bench for imm_gen_block. Each driven cycle pushes the value
// the reference model expects into a queue; after the next rising edge the
// head of the queue is popped and compared against imm_out.
// Honours IMM_GEN_J_FORMAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_imm_gen_block;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [20:0] imm;
  logic [31:0] imm_out;

  always #5 clk = ~clk;

  imm_gen_block dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .imm     (imm),
    .imm_out (imm_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model written with plain integer arithmetic.
  function automatic logic [31:0] model(input logic r, input logic [2:0] op, input logic [20:0] im);
    int v;
    if (r) return 32'h0;
    case (op)
      3'b001: begin
        v = int'(im[11:0]);
        if (v >= 2048) v = v - 4096;
        return 32'(v);
      end
      3'b011: begin
        v = int'(im[11:0]);
        if (v >= 2048) v = v - 4096;
        return 32'(v * 2);
      end
      3'b100: begin
        v = int'(im[19:0]);
        return 32'(v * 4096);
      end
`ifdef IMM_GEN_J_FORMAT_EN
      3'b010: begin
        v = int'(im[19:0]);
        if (v >= 524288) v = v - 1048576;
        return 32'(v * 2);
      end
`endif
      default: return 32'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one cycle of stimulus, expectation pushed, result popped and
  // checked one edge later.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic [2:0] op, input logic [20:0] im, input string tag);
    @(negedge clk);
    rst    = r;
    opcode = op;
    imm    = im;
    exp_q.push_back(model(r, op, im));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), imm_out, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b1;
    opcode = 3'b000;
    imm    = '0;

    // Reset has priority over live inputs.
    drive(1'b1, 3'b100, 21'h1FFFFF, "reset_u");
    drive(1'b1, 3'b001, 21'h000800, "reset_i");

    // Directed vectors.
    drive(1'b0, 3'b001, 21'h0002AB, "i_pos");
    check("i_pos_const", imm_out, 32'h000002AB);
    drive(1'b0, 3'b001, 21'h000800, "i_neg");
    check("i_neg_const", imm_out, 32'hFFFFF800);
    drive(1'b0, 3'b001, 21'h1FF7FF, "i_unused_hi");
    drive(1'b0, 3'b011, 21'h000555, "b_pos");
    check("b_pos_const", imm_out, 32'h00000AAA);
    drive(1'b0, 3'b011, 21'h000FFF, "b_neg");
    check("b_neg_const", imm_out, 32'hFFFFFFFE);
    drive(1'b0, 3'b100, 21'h0ABCDE, "u_plain");
    check("u_plain_const", imm_out, 32'hABCDE000);
    drive(1'b0, 3'b100, 21'h1ABCDE, "u_bit20");
    check("u_bit20_const", imm_out, 32'hABCDE000);
    drive(1'b0, 3'b111, 21'h000000, "dflt_111_0");
    drive(1'b0, 3'b111, 21'h1FFFFF, "dflt_111_1");
    drive(1'b0, 3'b000, 21'h1FFFFF, "dflt_000");
    drive(1'b0, 3'b101, 21'h1FFFFF, "dflt_101");
    drive(1'b0, 3'b110, 21'h1FFFFF, "dflt_110");
    drive(1'b0, 3'b010, 21'h080000, "j_neg");
`ifdef IMM_GEN_J_FORMAT_EN
    check("j_neg_const", imm_out, 32'hFFF00000);
`else
    check("j_off_const", imm_out, 32'h00000000);
`endif
    drive(1'b0, 3'b010, 21'h17FFFF, "j_pos");

    // Reset mid-stream, then release with the same inputs held.
    drive(1'b0, 3'b001, 21'h000123, "pre_rst");
    drive(1'b1, 3'b100, 21'h0ABCDE, "mid_rst");
    check("mid_rst_const", imm_out, 32'h00000000);
    drive(1'b0, 3'b100, 21'h0ABCDE, "post_rst");
    check("post_rst_const", imm_out, 32'hABCDE000);

    // Random back-to-back traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      drive((($urandom_range(0, 19)) == 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            21'($urandom_range(0, 21'h1FFFFF)),
            "rand");
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_imm_gen_block
